// File: rtl/dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : dispatcher
// Description : Single-entry instruction dispatcher. Holds one fetched
//               instruction, decodes it, and resolves its source operands
//               against the regfile, the ROB and the same-cycle ALU/LSB
//               broadcasts. When the target queue and the ROB have room, it
//               registers a one-cycle dispatch strobe to the RS or the LSB.
//               Illegal opcodes are drained without a strobe.
// Ports       : clk, rst, rdy, rollback       - clock, sync reset, enable, flush
//               if_valid/if_inst/if_pc/if_ready - fetch handshake
//               reg_rs1/reg_rs2 (+ _val/_rob_id) - regfile lookup
//               rob_q1/q2 pos/ready/val         - ROB readiness query
//               alu_*/lsb_* result broadcasts   - same-cycle forwarding
//               rs_full/lsb_full/rob_full       - downstream back-pressure
//               rs_en/lsb_en/rob_en/rename_en   - registered dispatch strobes
//               out_*                           - registered dispatch payload
// Revision    : 1.0 - initial release
// ============================================================================
module dispatcher (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        if_valid,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic [4:0]  reg_rs1,
    output logic [4:0]  reg_rs2,
    input  logic [31:0] reg_rs1_val,
    input  logic [31:0] reg_rs2_val,
    input  logic [4:0]  reg_rs1_rob_id,
    input  logic [4:0]  reg_rs2_rob_id,
    output logic [3:0]  rob_q1_pos,
    output logic [3:0]  rob_q2_pos,
    input  logic        rob_q1_ready,
    input  logic        rob_q2_ready,
    input  logic [31:0] rob_q1_val,
    input  logic [31:0] rob_q2_val,
    input  logic        alu_result,
    input  logic [3:0]  alu_rob_pos,
    input  logic [31:0] alu_val,
    input  logic        lsb_result,
    input  logic [3:0]  lsb_rob_pos,
    input  logic [31:0] lsb_val,
    input  logic        rs_full,
    input  logic        lsb_full,
    input  logic        rob_full,
    output logic        rs_en,
    output logic        lsb_en,
    output logic        rob_en,
    output logic        rename_en,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_func3,
    output logic        out_func1,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic [31:0] out_pc,
    output logic [3:0]  out_rob_pos,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val,
    output logic [4:0]  out_rs1_rob_id,
    output logic [4:0]  out_rs2_rob_id
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    // State
    logic        r_buf_valid;
    logic [31:0] r_buf_inst;
    logic [31:0] r_buf_pc;
    logic [3:0]  r_rob_tail;
    logic        r_rs_en, r_lsb_en, r_rob_en, r_rename_en;
    logic [6:0]  r_opcode;
    logic [2:0]  r_func3;
    logic        r_func1;
    logic [4:0]  r_rd;
    logic [31:0] r_imm, r_pc;
    logic [3:0]  r_rob_pos;
    logic [31:0] r_rs1_val, r_rs2_val;
    logic [4:0]  r_rs1_id, r_rs2_id;

    // Decode of the buffered instruction
    logic [6:0]  w_op;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic        w_is_lsb, w_is_rs, w_illegal;
    logic        w_use_rs1, w_use_rs2, w_writes_rd;
    logic        w_fire, w_accept, w_legal_fire;
    logic        w_fwd1, w_fwd2;
    logic [31:0] w_imm;
    logic [36:0] w_opnd1, w_opnd2;

    assign w_op  = r_buf_inst[6:0];
    assign w_rd  = r_buf_inst[11:7];
    assign w_f3  = r_buf_inst[14:12];
    assign w_rs1 = r_buf_inst[19:15];
    assign w_rs2 = r_buf_inst[24:20];

    assign w_is_lsb  = (w_op == c_OP_LOAD) || (w_op == c_OP_STORE);
    assign w_is_rs   = (w_op == c_OP_LUI) || (w_op == c_OP_AUIPC) || (w_op == c_OP_JAL) ||
                       (w_op == c_OP_JALR) || (w_op == c_OP_BRANCH) || (w_op == c_OP_IMM) ||
                       (w_op == c_OP_REG);
    assign w_illegal = !(w_is_lsb || w_is_rs);

    assign w_use_rs1   = !((w_op == c_OP_LUI) || (w_op == c_OP_AUIPC) || (w_op == c_OP_JAL));
    assign w_use_rs2   = (w_op == c_OP_REG) || (w_op == c_OP_STORE) || (w_op == c_OP_BRANCH);
    assign w_writes_rd = !((w_op == c_OP_BRANCH) || (w_op == c_OP_STORE)) && (w_rd != 5'd0);

    // Illegal entries drain regardless of back-pressure so fetch never wedges.
    assign w_fire       = r_buf_valid &&
                          (w_illegal || (!rob_full && (w_is_lsb ? !lsb_full : !rs_full)));
    assign w_legal_fire = w_fire && !w_illegal;
    assign if_ready     = rdy && (!r_buf_valid || w_fire);
    assign w_accept     = if_valid && if_ready;

    // Immediate generation
    always_comb begin
        w_imm = 32'd0;
        case (w_op)
            c_OP_LOAD, c_OP_IMM, c_OP_JALR:
                w_imm = {{20{r_buf_inst[31]}}, r_buf_inst[31:20]};
            c_OP_STORE:
                w_imm = {{20{r_buf_inst[31]}}, r_buf_inst[31:25], r_buf_inst[11:7]};
            c_OP_BRANCH:
                w_imm = {{19{r_buf_inst[31]}}, r_buf_inst[31], r_buf_inst[7],
                         r_buf_inst[30:25], r_buf_inst[11:8], 1'b0};
            c_OP_LUI, c_OP_AUIPC:
                w_imm = {r_buf_inst[31:12], 12'd0};
            c_OP_JAL:
                w_imm = {{11{r_buf_inst[31]}}, r_buf_inst[31], r_buf_inst[19:12],
                         r_buf_inst[20], r_buf_inst[30:21], 1'b0};
            default:
                w_imm = 32'd0;
        endcase
    end

    // The regfile only sees last cycle's rename at the coming edge, so a
    // source naming that rd must take the freshly allocated ROB tag instead.
    assign reg_rs1 = w_rs1;
    assign reg_rs2 = w_rs2;
    assign w_fwd1  = r_rename_en && (r_rd == w_rs1);
    assign w_fwd2  = r_rename_en && (r_rd == w_rs2);
    assign rob_q1_pos = w_fwd1 ? r_rob_pos : reg_rs1_rob_id[3:0];
    assign rob_q2_pos = w_fwd2 ? r_rob_pos : reg_rs2_rob_id[3:0];

    // Returns {value, rob_id}; rob_id bit4 set means still pending.
    function automatic logic [36:0] f_resolve(
        input logic        used,
        input logic [4:0]  idx,
        input logic        fwd,
        input logic [3:0]  fwd_pos,
        input logic [31:0] rf_val,
        input logic [4:0]  rf_tag,
        input logic        rob_rdy,
        input logic [31:0] rob_val,
        input logic        alu_hit,
        input logic [3:0]  alu_pos,
        input logic [31:0] alu_v,
        input logic        lsb_hit,
        input logic [3:0]  lsb_pos,
        input logic [31:0] lsb_v
    );
        if (!used || idx == 5'd0)
            f_resolve = {32'd0, 5'd0};
        else if (fwd)
            f_resolve = {32'd0, 1'b1, fwd_pos};
        else if (!rf_tag[4])
            f_resolve = {rf_val, 5'd0};
        else if (rob_rdy)
            f_resolve = {rob_val, 5'd0};
        else if (alu_hit && alu_pos == rf_tag[3:0])
            f_resolve = {alu_v, 5'd0};
        else if (lsb_hit && lsb_pos == rf_tag[3:0])
            f_resolve = {lsb_v, 5'd0};
        else
            f_resolve = {32'd0, rf_tag};
    endfunction

    assign w_opnd1 = f_resolve(w_use_rs1, w_rs1, w_fwd1, r_rob_pos, reg_rs1_val, reg_rs1_rob_id,
                               rob_q1_ready, rob_q1_val, alu_result, alu_rob_pos, alu_val,
                               lsb_result, lsb_rob_pos, lsb_val);
    assign w_opnd2 = f_resolve(w_use_rs2, w_rs2, w_fwd2, r_rob_pos, reg_rs2_val, reg_rs2_rob_id,
                               rob_q2_ready, rob_q2_val, alu_result, alu_rob_pos, alu_val,
                               lsb_result, lsb_rob_pos, lsb_val);

    always_ff @(posedge clk) begin
        if (rst || (rdy && rollback)) begin
            r_buf_valid <= 1'b0;
            r_buf_inst  <= 32'd0;
            r_buf_pc    <= 32'd0;
            r_rob_tail  <= 4'd0;
            r_rs_en     <= 1'b0;
            r_lsb_en    <= 1'b0;
            r_rob_en    <= 1'b0;
            r_rename_en <= 1'b0;
            r_opcode    <= 7'd0;
            r_func3     <= 3'd0;
            r_func1     <= 1'b0;
            r_rd        <= 5'd0;
            r_imm       <= 32'd0;
            r_pc        <= 32'd0;
            r_rob_pos   <= 4'd0;
            r_rs1_val   <= 32'd0;
            r_rs2_val   <= 32'd0;
            r_rs1_id    <= 5'd0;
            r_rs2_id    <= 5'd0;
        end else if (rdy) begin
            if (w_accept) begin
                r_buf_valid <= 1'b1;
                r_buf_inst  <= if_inst;
                r_buf_pc    <= if_pc;
            end else if (w_fire) begin
                r_buf_valid <= 1'b0;
            end

            r_rs_en     <= w_legal_fire && !w_is_lsb;
            r_lsb_en    <= w_legal_fire && w_is_lsb;
            r_rob_en    <= w_legal_fire;
            r_rename_en <= w_legal_fire && w_writes_rd;

            if (w_legal_fire) begin
                r_opcode   <= w_op;
                r_func3    <= w_f3;
                r_func1    <= ((w_op == c_OP_REG) || (w_op == c_OP_IMM && w_f3 == 3'b101))
                              ? r_buf_inst[30] : 1'b0;
                r_rd       <= w_writes_rd ? w_rd : 5'd0;
                r_imm      <= w_imm;
                r_pc       <= r_buf_pc;
                r_rob_pos  <= r_rob_tail;
                r_rob_tail <= r_rob_tail + 4'd1;
                r_rs1_val  <= w_opnd1[36:5];
                r_rs1_id   <= w_opnd1[4:0];
                r_rs2_val  <= w_opnd2[36:5];
                r_rs2_id   <= w_opnd2[4:0];
            end
        end
    end

    assign rs_en          = r_rs_en;
    assign lsb_en         = r_lsb_en;
    assign rob_en         = r_rob_en;
    assign rename_en      = r_rename_en;
    assign out_opcode     = r_opcode;
    assign out_func3      = r_func3;
    assign out_func1      = r_func1;
    assign out_rd         = r_rd;
    assign out_imm        = r_imm;
    assign out_pc         = r_pc;
    assign out_rob_pos    = r_rob_pos;
    assign out_rs1_val    = r_rs1_val;
    assign out_rs2_val    = r_rs2_val;
    assign out_rs1_rob_id = r_rs1_id;
    assign out_rs2_rob_id = r_rs2_id;

endmodule
`default_nettype wire

// File: doc/dispatcher.md
DISPATCHER -- requirements
Module: dispatcher

Interface
REQ-001 clk  in  1  clock, all state on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 rdy  in  1  global enable; low = every register holds.
REQ-004 rollback  in  1  misprediction flush, synchronous.
REQ-005 if_valid / if_inst / if_pc  in  1/32/32  fetched instruction offer.
REQ-006 if_ready  out  1  dispatcher accepts offer this cycle (combinational).
REQ-007 reg_rs1 / reg_rs2  out  5/5  register-file lookup indices (combinational from buffer).
REQ-008 reg_rs1_val, reg_rs2_val / reg_rs1_rob_id, reg_rs2_rob_id  in  32/5  regfile value and rename tag; tag bit4=1 means pending on ROB pos tag[3:0].
REQ-009 rob_q1_pos / rob_q2_pos  out  4/4  ROB readiness query positions.
REQ-010 rob_q1_ready, rob_q2_ready / rob_q1_val, rob_q2_val  in  1/32  ROB entry completed and its value.
REQ-011 alu_result, lsb_result / *_rob_pos / *_val  in  1/4/32  same-cycle broadcasts.
REQ-012 rs_full / lsb_full / rob_full  in  1  downstream cannot take an entry next edge.
REQ-013 rs_en / lsb_en / rob_en / rename_en  out  1  registered one-cycle dispatch strobes.
REQ-014 out_opcode 7, out_func3 3, out_func1 1, out_rd 5, out_imm 32, out_pc 32, out_rob_pos 4  out  registered fields shared by RS/LSB/ROB/regfile.
REQ-015 out_rs1_val, out_rs2_val 32 / out_rs1_rob_id, out_rs2_rob_id 5  out  registered operands; rob_id bit4=0 means value valid.

Function
REQ-016 State: one-entry buffer (buf_valid, buf_inst, buf_pc), 4-bit rob_tail counter, output register set.
REQ-017 Class: opcode 0000011/0100011 -> LSB; 0110111, 0010111, 1101111, 1100111, 1100011, 0010011, 0110011 -> RS; any other -> illegal.
REQ-018 fire = buf_valid & ~rob_full & (LSB-class ? ~lsb_full : ~rs_full); illegal entries fire unconditionally with no strobe.
REQ-019 if_ready = ~buf_valid | fire; accept (if_valid & if_ready) loads buffer at edge, else buf_valid clears on fire.
REQ-020 On legal fire: rob_en=1, rs_en or lsb_en=1 per class, out_rob_pos=rob_tail, rob_tail increments mod 16 (15->0).
REQ-021 rename_en=1 on legal fire iff class writes rd (not 1100011, not 0100011) and rd!=0; out_rd=0 otherwise.
REQ-022 Strobes are 1 for exactly one cycle per fire; 0 in every non-fire cycle; fields hold last value.
REQ-023 Immediate: I/S/B/U/J formats, sign-extended from inst[31]; B/J bit0=0; U = inst[31:12]<<12; R-type imm=0.
REQ-024 out_func1 = inst[30] for 0110011 and for 0010011 with func3=101, else 0.
REQ-025 Operands absent from format (rs1 for LUI/AUIPC/JAL; rs2 for non-R/S/B) -> val=0, rob_id=0.
REQ-026 Operand resolution priority: (a) index 0 -> 0 ready; (b) previous-cycle rename_en with out_rd==index -> pending {1,out_rob_pos}; (c) regfile tag bit4=0 -> regfile value; (d) rob_qN_ready -> ROB value; (e) alu_result or lsb_result matching pos -> broadcast value, ALU first; (f) pending tag unchanged.
REQ-027 rob_qN_pos = regfile tag[3:0], or out_rob_pos when (b) applies.
REQ-028 rs1==rs2==rd of one instruction: lookups use pre-rename state; rename takes effect only for following instruction.
REQ-029 Throughput one instruction per cycle with no stalls; fetch-to-strobe latency 2 edges (buffer, output).
REQ-030 Stall: buffer and fields hold while fire=0; no instruction is lost or duplicated.

Reset
REQ-031 rst or rollback: buf_valid=0, rob_tail=0, all strobes 0, fields 0; rollback beats simultaneous if_valid and fire.
REQ-032 rdy=0: no state changes, strobes hold, if_ready forced 0.

Verification
REQ-033 addi x1,x0,5 (0x00500093) with empty regfile -> next cycle rs_en=rob_en=rename_en=1, imm=5, rs1 rob_id=0, rd=1, rob_pos=0.
REQ-034 addi x1 then add x2,x1,x1 back-to-back -> second dispatch rs1/rs2 rob_id=5'h10, rob_pos=1.
REQ-035 lw with lsb_full=1 for 3 cycles -> lsb_en stays 0, if_ready=0; on release single lsb_en pulse, no rs_en.
REQ-036 Pending rs1 tag 5'h13, alu_result pos 3 val 0x1234 same cycle -> out_rs1_val=0x1234, rob_id=0.
REQ-037 17 dispatches -> rob_pos sequence 0..15,0; rollback mid-stream -> buffer emptied, next dispatch rob_pos=0.
REQ-038 Opcode 0x7F -> buffer drains, no strobe, rob_tail unchanged.
